// File: rtl/arp_tx_frame.sv
// arp_tx_frame: serialises one ARP request/reply (preamble, SFD, 60-byte frame, FCS) onto a GMII byte lane.
// Latency: first preamble byte on the cycle after the accepted i_start; o_done one cycle after the last FCS byte.
// Backpressure: none toward the PHY; upstream sees o_rdy=0 while busy and any i_start then is dropped.
//
// Ports:
//   clk, rst              byte clock, synchronous active-high reset
//   i_pkt_type, i_start   1 = request, 2 = reply; start is taken only while o_rdy = 1
//   i_sha/i_spa/i_tha/i_tpa  ARP address fields, latched on the accepted start
//   o_phy_data, o_phy_tx_en  PHY transmit byte and enable (data is 0x00 when enable is low)
//   o_rdy, o_done         idle indication, end-of-frame pulse
//
// Build option: define ARP_TX_IFG_EN to hold off o_done/o_rdy for IFG_LEN idle byte-times after the FCS.
module arp_tx_frame #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_pkt_type,
  input  logic        i_start,
  input  logic [47:0] i_sha,
  input  logic [31:0] i_spa,
  input  logic [47:0] i_tha,
  input  logic [31:0] i_tpa,
  output logic [7:0]  o_phy_data,
  output logic        o_phy_tx_en,
  output logic        o_rdy,
  output logic        o_done
);

  // The byte counter doubles as the IFG counter, so widen it only if IFG_LEN needs more than 7 bits.
  localparam int unsigned IfgW = $clog2(IFG_LEN + 1);
  localparam int unsigned CntW = (IfgW > 7) ? IfgW : 7;

  // Stream indices of the byte currently on the output.
  localparam logic [CntW-1:0] SfdIdx   = CntW'(PREAMBLE_LEN);
  localparam logic [CntW-1:0] FcsBase  = CntW'(PREAMBLE_LEN + 61);
  localparam logic [CntW-1:0] FrameEnd = CntW'(PREAMBLE_LEN + 65);
`ifdef ARP_TX_IFG_EN
  localparam logic [CntW-1:0] IfgLast  = CntW'(IFG_LEN);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_FRAME,
    S_FCS,
    S_IFG
  } state_t;

  // state_q names the phase of the byte currently being driven; cnt_q is its index in the stream.
  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     crc_q;
  logic            is_reply_q;
  logic [47:0]     sha_q;
  logic [31:0]     spa_q;
  logic [47:0]     tha_q;
  logic [31:0]     tpa_q;
  logic [7:0]      data_q;
  logic            tx_en_q;
  logic            rdy_q;
  logic            done_q;

  logic [CntW-1:0] cnt_d;
  int              fb_i;
  logic [7:0]      fb_d;
  logic [31:0]     crc_d;
  logic [1:0]      fcs_sel;
  logic [7:0]      fcs_d;
  logic            start_ok;

  // One byte of the 60-byte Ethernet+ARP frame, i = 0 is the first destination MAC byte.
  function automatic logic [7:0] frame_byte(input int i, input logic rep,
                                            input logic [47:0] sha, input logic [31:0] spa,
                                            input logic [47:0] tha, input logic [31:0] tpa);
    logic [7:0] b;
    b = 8'h00;
    if (i < 6) begin
      b = rep ? 8'(tha >> (8 * (5 - i))) : 8'hFF;
    end else if (i < 12) begin
      b = 8'(sha >> (8 * (11 - i)));
    end else if (i < 22) begin
      case (i)
        12:      b = 8'h08;
        13:      b = 8'h06;
        14:      b = 8'h00;
        15:      b = 8'h01;
        16:      b = 8'h08;
        17:      b = 8'h00;
        18:      b = 8'h06;
        19:      b = 8'h04;
        20:      b = 8'h00;
        default: b = rep ? 8'h02 : 8'h01;
      endcase
    end else if (i < 28) begin
      b = 8'(sha >> (8 * (27 - i)));
    end else if (i < 32) begin
      b = 8'(spa >> (8 * (31 - i)));
    end else if (i < 38) begin
      b = rep ? 8'(tha >> (8 * (37 - i))) : 8'h00;
    end else if (i < 42) begin
      b = 8'(tpa >> (8 * (41 - i)));
    end
    return b;
  endfunction

  // Reflected CRC-32 advanced by one byte, data bits consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    cnt_d    = cnt_q + CntW'(1);
    fb_i     = int'(cnt_d) - int'(PREAMBLE_LEN) - 1;
    fb_d     = frame_byte(fb_i, is_reply_q, sha_q, spa_q, tha_q, tpa_q);
    crc_d    = crc_byte(crc_q, fb_d);
    // FCS goes out low byte first as the complement of the running CRC.
    fcs_sel  = cnt_d[1:0] - FcsBase[1:0];
    fcs_d    = 8'(~crc_q >> {fcs_sel, 3'b000});
    start_ok = i_start && rdy_q && ((i_pkt_type == 2'd1) || (i_pkt_type == 2'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc_q      <= 32'hFFFFFFFF;
      is_reply_q <= 1'b0;
      sha_q      <= '0;
      spa_q      <= '0;
      tha_q      <= '0;
      tpa_q      <= '0;
      data_q     <= 8'h00;
      tx_en_q    <= 1'b0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          data_q  <= 8'h00;
          tx_en_q <= 1'b0;
          rdy_q   <= 1'b1;
          if (start_ok) begin
            is_reply_q <= (i_pkt_type == 2'd2);
            sha_q      <= i_sha;
            spa_q      <= i_spa;
            tha_q      <= i_tha;
            tpa_q      <= i_tpa;
            crc_q      <= 32'hFFFFFFFF;
            cnt_q      <= '0;
            data_q     <= 8'h55;
            tx_en_q    <= 1'b1;
            rdy_q      <= 1'b0;
            state_q    <= S_PREAMBLE;
          end
        end

        S_PREAMBLE: begin
          cnt_q <= cnt_d;
          if (cnt_d == SfdIdx) begin
            data_q  <= 8'hD5;
            state_q <= S_SFD;
          end else begin
            data_q <= 8'h55;
          end
        end

        S_SFD: begin
          cnt_q   <= cnt_d;
          data_q  <= fb_d;
          crc_q   <= crc_d;
          state_q <= S_FRAME;
        end

        S_FRAME: begin
          cnt_q <= cnt_d;
          if (cnt_d == FcsBase) begin
            // crc_q already covers all 60 frame bytes here.
            data_q  <= fcs_d;
            state_q <= S_FCS;
          end else begin
            data_q <= fb_d;
            crc_q  <= crc_d;
          end
        end

        S_FCS: begin
          if (cnt_d == FrameEnd) begin
            data_q  <= 8'h00;
            tx_en_q <= 1'b0;
`ifdef ARP_TX_IFG_EN
            cnt_q   <= CntW'(1);
            state_q <= S_IFG;
`else
            cnt_q   <= '0;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q  <= cnt_d;
            data_q <= fcs_d;
          end
        end

`ifdef ARP_TX_IFG_EN
        S_IFG: begin
          // cnt_q counts IFG cycles 1..IFG_LEN; the release lands one cycle after the last one.
          if (cnt_q == IfgLast) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif

        default: begin
          cnt_q   <= '0;
          data_q  <= 8'h00;
          tx_en_q <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_phy_data  = data_q;
  assign o_phy_tx_en = tx_en_q;
  assign o_rdy       = rdy_q;
  assign o_done      = done_q;

endmodule
